// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory arbiter.
// Holds the arbiter state type, the memory geometry defaults, and the
// round-robin helper functions used by the picker and the top.
// Port indices are carried in 2 bits so that up to 4 requesters fit.
package dmem_pkg;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

    localparam int DMEM_ADDR_W  = 10;
    localparam int DMEM_DATA_W  = 8;
    localparam int DMEM_MAX_REQ = 4;

    // Advance a port index by one, wrapping from n-1 back to 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return 2'd0;
        end
        return idx + 2'd1;
    endfunction

    // Round-robin winner: the first set bit of req found by searching
    // upwards from ptr and wrapping at n. The result is meaningless when
    // req is all zero, so callers qualify it with |req.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr, input int n);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        idx   = ptr;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < DMEM_MAX_REQ; i++) begin
            if (i < n) begin
                if (!found && req[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
                idx = next_idx(idx, n);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Combinational round-robin priority encoder.
// Ports:
//   req  in   N_REQ  request vector
//   ptr  in   2      index where the search starts (must be < N_REQ)
//   idx  out  2      winning index, valid when vld=1
//   vld  out  1      at least one request present
module dmem_rr_picker
    import dmem_pkg::*;
#(
    parameter int N_REQ = 2
)(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       idx,
    output logic             vld
);

    assign idx = rr_pick(4'(req), ptr, N_REQ);
    assign vld = |req;

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbiter sharing one single-port byte-wide data memory between N_REQ
// requesters (port 0 = core load/store unit, port 1 = DMA/debug loader).
// At most one access is granted per cycle; read data comes back one cycle
// later to the port that issued the read. A port may lock the memory for up
// to MAX_LOCK consecutive cycles; a starvation guard breaks long locks.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req/i_we/i_lock        per-port request, write select, lock request
//   i_addr/i_wdata           per-port address and write data (packed by port)
//   o_gnt                    one-hot grant, combinational
//   o_rvalid/o_rdata         read return, routed to the issuing port
//   o_mem_addr/o_mem_wdata   memory address and write data
//   o_mem_we/o_mem_re        memory strobes, never both high
//   i_mem_rdata              registered read data from the memory
module data_memory_arbiter
    import dmem_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_LOCK = 16
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_we,
    input  logic [N_REQ-1:0]        i_lock,
    input  logic [N_REQ*ADDR_W-1:0] i_addr,
    input  logic [N_REQ*DATA_W-1:0] i_wdata,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [N_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]       o_rdata,
    output logic [ADDR_W-1:0]       o_mem_addr,
    output logic [DATA_W-1:0]       o_mem_wdata,
    output logic                    o_mem_we,
    output logic                    o_mem_re,
    input  logic [DATA_W-1:0]       i_mem_rdata
);

    // The starvation counters saturate at 255, so a threshold above that
    // simply never fires; the extra bit keeps the compare honest.
    localparam logic [8:0] STARVE_TH = 9'(2 * MAX_LOCK);
    localparam logic [7:0] LOCK_MAX  = 8'(MAX_LOCK);

    arb_state_t       state, state_d;
    logic [1:0]       owner, owner_d;
    logic [1:0]       rr_ptr, rr_d;
    logic [7:0]       lock_cnt, lock_d;
    logic [7:0]       starve_cnt [N_REQ];
    logic [1:0]       rd_owner;
    logic             rd_owner_vld;

    logic [1:0]       pick_ptr, pick_idx, win_idx, starve_idx, rd_sel;
    logic             pick_vld, starve_any, starve_exit, own_hold;
    logic             owner_req, owner_lock, win_lock;
    logic [N_REQ-1:0] gnt;

    // Search start for the picker: normally the rr pointer, but on the cycle
    // a lock ends the search starts just past the owner so it cannot win again.
    assign pick_ptr = (state == ARB_OWN) ? next_idx(owner, N_REQ) : rr_ptr;

    dmem_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req (i_req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Starvation detection. Any saturated-high counter ends a lock; among
    // starved ports that are still requesting, the lowest index takes the grant.
    always_comb begin
        starve_any  = 1'b0;
        starve_exit = 1'b0;
        starve_idx  = 2'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if ({1'b0, starve_cnt[k]} >= STARVE_TH) begin
                starve_exit = 1'b1;
                if (i_req[k]) begin
                    starve_any = 1'b1;
                    starve_idx = 2'(k);
                end
            end
        end
    end

    // Per-port bits of the owner and of the arbitration winner.
    always_comb begin
        win_idx    = starve_any ? starve_idx : pick_idx;
        owner_req  = 1'b0;
        owner_lock = 1'b0;
        win_lock   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (2'(k) == owner) begin
                owner_req  = i_req[k];
                owner_lock = i_lock[k];
            end
            if (2'(k) == win_idx) begin
                win_lock = i_lock[k];
            end
        end
    end

    // Next-state and grant logic. While a lock holds, only the owner can be
    // granted (an idle lock cycle still counts). Any other cycle, including
    // the one where a lock ends, arbitrates normally so no bubble appears.
    always_comb begin
        gnt     = '0;
        state_d = state;
        owner_d = owner;
        rr_d    = rr_ptr;
        lock_d  = lock_cnt;
        own_hold = (state == ARB_OWN) && owner_lock && (lock_cnt < LOCK_MAX) && !starve_exit;
        rd_sel  = own_hold ? owner : win_idx;
        if (own_hold) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (2'(k) == owner) begin
                    gnt[k] = owner_req;
                end
            end
            lock_d = lock_cnt + 8'd1;
        end else begin
            state_d = ARB_IDLE;
            lock_d  = '0;
            if (state == ARB_OWN) begin
                rr_d = pick_ptr;
            end
            if (pick_vld) begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (2'(k) == win_idx) begin
                        gnt[k] = 1'b1;
                    end
                end
                rr_d = next_idx(win_idx, N_REQ);
                if (win_lock) begin
                    state_d = ARB_OWN;
                    owner_d = win_idx;
                    lock_d  = 8'd1;
                end
            end
        end
    end

    // Memory-side mux. With no grant the port 0 values are forwarded and
    // both strobes stay low.
    always_comb begin
        o_mem_addr  = i_addr[0 +: ADDR_W];
        o_mem_wdata = i_wdata[0 +: DATA_W];
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                o_mem_addr  = i_addr[k*ADDR_W +: ADDR_W];
                o_mem_wdata = i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign o_gnt    = gnt;
    assign o_mem_we = |(gnt & i_we);
    assign o_mem_re = |(gnt & ~i_we);
    assign o_rdata  = i_mem_rdata;

    // Read return is routed by the owner tag captured with the read grant.
    always_comb begin
        o_rvalid = '0;
        for (int k = 0; k < N_REQ; k++) begin
            o_rvalid[k] = rd_owner_vld && (rd_owner == 2'(k));
        end
    end

    // State, counters and the read-owner tag. Reset drops any lock and
    // cancels a read granted in the reset cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ARB_IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            lock_cnt     <= '0;
            rd_owner     <= '0;
            rd_owner_vld <= 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                starve_cnt[k] <= '0;
            end
        end else begin
            state        <= state_d;
            owner        <= owner_d;
            rr_ptr       <= rr_d;
            lock_cnt     <= lock_d;
            rd_owner     <= rd_sel;
            rd_owner_vld <= o_mem_re;
            for (int k = 0; k < N_REQ; k++) begin
                if (gnt[k]) begin
                    starve_cnt[k] <= '0;
                end else if (i_req[k] && (starve_cnt[k] != 8'hFF)) begin
                    starve_cnt[k] <= starve_cnt[k] + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter with two requesters and a
// behavioural 1 kB memory with registered read. Expected read returns are
// queued when a read is granted and compared when o_rvalid is due.
module tb_data_memory_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we, lock;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gnt, rvalid;
    logic [7:0]  rdata, memWdata, memRdata;
    logic [9:0]  memAddr;
    logic        memWe, memRe;

    logic [7:0]  mem [1024];
    logic        memReady = 1'b0;

    typedef struct {
        int         port;
        logic [7:0] data;
    } rdExp_t;
    rdExp_t sbQ[$];

    int checks = 0;
    int errors = 0;

    data_memory_arbiter #(
        .N_REQ    (2),
        .ADDR_W   (10),
        .DATA_W   (8),
        .MAX_LOCK (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_we        (we),
        .i_lock      (lock),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_mem_addr  (memAddr),
        .o_mem_wdata (memWdata),
        .o_mem_we    (memWe),
        .o_mem_re    (memRe),
        .i_mem_rdata (memRdata)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Behavioural memory: filled with a known pattern on the first edge,
    // then written and read under the arbiter's strobes.
    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= 8'(i);
            end
            memReady <= 1'b1;
        end else begin
            if (memWe) mem[memAddr] <= memWdata;
            if (memRe) memRdata <= mem[memAddr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle checks: pending read return, strobe exclusivity, grant shape,
    // memory mux, then queue the expected return for any read granted now.
    task automatic monitorCycle();
        rdExp_t     e;
        logic [1:0] expV;
        expV = 2'b00;
        if (sbQ.size() > 0) begin
            e    = sbQ.pop_front();
            expV = 2'(1 << e.port);
            checkOutput("rdata", 32'(rdata), 32'(e.data));
        end
        checkOutput("rvalid", 32'(rvalid), 32'(expV));
        checkOutput("strobeExcl", 32'(memWe & memRe), 32'd0);
        checkOutput("gntOneHot", 32'($onehot0(gnt)), 32'd1);
        checkOutput("gntSubset", 32'(gnt & ~req), 32'd0);
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (gnt[k]) begin
                    checkOutput("memAddr", 32'(memAddr), 32'(addr[k*10 +: 10]));
                    if (we[k]) begin
                        checkOutput("memWdata", 32'(memWdata), 32'(wdata[k*8 +: 8]));
                    end else begin
                        e.port = k;
                        e.data = mem[addr[k*10 +: 10]];
                        sbQ.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] rq, input logic [1:0] w,
                                 input logic [1:0] l, input logic [9:0] a0, input logic [9:0] a1,
                                 input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clk);
        rst   = r;
        req   = rq;
        we    = w;
        lock  = l;
        addr  = {a1, a0};
        wdata = {d1, d0};
        #1;
        monitorCycle();
    endtask

    initial begin
        logic [1:0] nr, nw, nl;
        logic [9:0] na [2];
        logic [7:0] nd [2];

        // Reset held two cycles while both ports request.
        rst   = 1'b1;
        req   = 2'b11;
        we    = 2'b00;
        lock  = 2'b00;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rstRvalid", 32'(rvalid), 32'd0);
        checkOutput("rstRrPtr", 32'(dut.rr_ptr), 32'd0);
        applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
        checkOutput("firstGnt", 32'(gnt), 32'h1);

        // Write then read back the top address on port 0.
        applyStimulus(1'b0, 2'b01, 2'b01, 2'b00, 10'h3FF, 10'h000, 8'hA5, 8'h00);
        checkOutput("wrGnt", 32'(gnt), 32'h1);
        checkOutput("wrStrobe", 32'(memWe), 32'd1);
        applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 10'h3FF, 10'h000, 8'h00, 8'h00);
        checkOutput("rdGnt", 32'(gnt), 32'h1);
        checkOutput("rdStrobe", 32'(memRe), 32'd1);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 10'h3FF, 10'h000, 8'h00, 8'h00);
        checkOutput("rdBackValid", 32'(rvalid), 32'h1);
        checkOutput("rdBackData", 32'(rdata), 32'hA5);

        // A port 1 read parks the pointer at 0, then both ports contend.
        applyStimulus(1'b0, 2'b10, 2'b00, 2'b00, 10'h3FF, 10'h001, 8'h00, 8'h00);
        checkOutput("p1Gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 10'h3FF, 10'h001, 8'h00, 8'h00);
            checkOutput("rrGnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Port 0 access moves the pointer to 1, then port 1 locks.
        applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00);
        checkOutput("preLockGnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 2'b11, 2'b00, 2'b10, 10'h010, 10'h020, 8'h00, 8'h00);
            checkOutput("lockGnt", 32'(gnt), (i == 16) ? 32'h1 : 32'h2);
        end
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);

        // Random traffic; a port keeps its request stable until granted.
        for (int c = 0; c < 10000; c++) begin
            nr = req;
            nw = we;
            na[0] = addr[9:0];
            na[1] = addr[19:10];
            nd[0] = wdata[7:0];
            nd[1] = wdata[15:8];
            for (int k = 0; k < 2; k++) begin
                if (!req[k] || gnt[k]) begin
                    nr[k] = ($urandom_range(0, 3) != 0);
                    nw[k] = 1'($urandom_range(0, 1));
                    na[k] = 10'($urandom_range(0, 15));
                    nd[k] = 8'($urandom_range(0, 255));
                end
            end
            nl = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            applyStimulus(1'b0, nr, nw, nl, na[0], na[1], nd[0], nd[1]);
        end
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);

        // Reset lands on the cycle port 1 is granted a read.
        applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 10'h000, 10'h3FF, 8'h00, 8'h00);
        checkOutput("rstCycleGnt", 32'(gnt), 32'h2);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
        checkOutput("midRstRvalid", 32'(rvalid), 32'd0);
        checkOutput("midRstState", 32'(dut.state), 32'(ARB_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
